// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide controller.
// MULDIV_ACC_EN adds the ACC state used by the multiply-accumulate ops.
package muldiv_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned DLEN        = 64;
  localparam int unsigned OP_W        = 5;
  localparam int unsigned CNT_W       = 3;
  localparam int unsigned MUL_LAT_DEF = 2;

  typedef logic [OP_W-1:0] op_t;

  // ALU op codes; anything not listed here is ignored by the controller
  localparam op_t OP_NOP   = 5'h00;
  localparam op_t OP_MULT  = 5'h10;
  localparam op_t OP_MULTU = 5'h11;
  localparam op_t OP_DIV   = 5'h12;
  localparam op_t OP_DIVU  = 5'h13;
  localparam op_t OP_MTHI  = 5'h14;
  localparam op_t OP_MTLO  = 5'h15;
  localparam op_t OP_MADD  = 5'h16;
  localparam op_t OP_MADDU = 5'h17;
  localparam op_t OP_MSUB  = 5'h18;
  localparam op_t OP_MSUBU = 5'h19;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_DONE = 3'd3
`ifdef MULDIV_ACC_EN
    , ST_ACC = 3'd4
`endif
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] rem;
    logic [XLEN-1:0] quo;
  } div_result_t;

  function automatic logic mul_is_signed(input op_t op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Handshake bundle between the HI/LO controller and the external divider.
interface muldiv_ctrl_if;
  import muldiv_pkg::*;

  logic            div_start_o;
  logic            div_signed_o;
  logic            div_annul_o;
  logic [XLEN-1:0] div_a_o;
  logic [XLEN-1:0] div_b_o;
  div_result_t     div_result_i;
  logic            div_ready_i;

  modport master (
    output div_start_o, div_signed_o, div_annul_o, div_a_o, div_b_o,
    input  div_result_i, div_ready_i
  );

  modport slave (
    input  div_start_o, div_signed_o, div_annul_o, div_a_o, div_b_o,
    output div_result_i, div_ready_i
  );
endinterface

// File: rtl/muldiv_ctrl_mul.sv
// Pipelined 33x33 signed multiplier; bit 32 of each operand selects signed or unsigned.
// The operand latch is the first stage, so the product is valid MUL_LAT edges after load.
module muldiv_mul
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            sgn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [DLEN-1:0] prod
);

  logic signed [XLEN:0] a_q;
  logic signed [XLEN:0] b_q;
  logic signed [DLEN-1:0] full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (load) begin
      a_q <= {sgn & a[XLEN-1], a};
      b_q <= {sgn & b[XLEN-1], b};
    end
  end

  // only the low 64 bits of the 66-bit product are architecturally visible
  assign full = DLEN'(a_q) * DLEN'(b_q);

  if (MUL_LAT <= 1) begin : g_comb
    assign prod = full;
  end else begin : g_pipe
    for (genvar s = 0; s < MUL_LAT - 1; s++) begin : g_stage
      logic [DLEN-1:0] q;
      if (s == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (!rst) q <= '0;
          else      q <= full;
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (!rst) q <= '0;
          else      q <= g_stage[s-1].q;
        end
      end
    end
    assign prod = g_stage[MUL_LAT-2].q;
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// HI/LO controller: sequences multiplies, external divides and MTHI/MTLO, stalling F/D/E.
// Define MULDIV_ACC_EN to add MADD/MADDU/MSUB/MSUBU with one extra ACC cycle.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            e_valid,
  input  op_t             e_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  muldiv_ctrl_if.master   dv
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mul_load, div_load;
  logic              div_start, div_annul;
  logic              hi_we, lo_we;
  logic [XLEN-1:0]   hi_d, lo_d;
  logic [DLEN-1:0]   prod;
  logic              div_sgn_q;
  logic [XLEN-1:0]   div_a_q, div_b_q;

`ifdef MULDIV_ACC_EN
  logic              acc_q, sub_q, acc_set, sub_set;
  logic [DLEN-1:0]   acc_sum;

  assign acc_sum = sub_q ? ({hi_o, lo_o} - prod) : ({hi_o, lo_o} + prod);

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= 1'b0;
      sub_q <= 1'b0;
    end else if (mul_load) begin
      acc_q <= acc_set;
      sub_q <= sub_set;
    end
  end
`endif

  muldiv_mul #(.MUL_LAT(MUL_LAT)) u_mul (
    .clk  (clk),
    .rst  (rst),
    .load (mul_load),
    .sgn  (mul_is_signed(e_op)),
    .a    (a),
    .b    (b),
    .prod (prod)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state, stall and HI/LO write selection; flush overrides everything
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_o   = 1'b0;
    mul_load  = 1'b0;
    div_load  = 1'b0;
    div_start = 1'b0;
    div_annul = 1'b0;
    hi_we     = 1'b0;
    lo_we     = 1'b0;
    hi_d      = hi_o;
    lo_d      = lo_o;
`ifdef MULDIV_ACC_EN
    acc_set   = 1'b0;
    sub_set   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (e_valid && !flush) begin
          case (e_op)
            OP_MULT, OP_MULTU: begin
              mul_load = 1'b1;
              stall_o  = 1'b1;
              cnt_d    = '0;
              state_d  = ST_MUL;
            end
`ifdef MULDIV_ACC_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
              mul_load = 1'b1;
              acc_set  = 1'b1;
              sub_set  = (e_op == OP_MSUB) || (e_op == OP_MSUBU);
              stall_o  = 1'b1;
              cnt_d    = '0;
              state_d  = ST_MUL;
            end
`endif
            OP_DIV, OP_DIVU: begin
              div_load = 1'b1;
              stall_o  = 1'b1;
              state_d  = ST_DIV;
            end
            OP_MTHI: begin
              hi_we = 1'b1;
              hi_d  = a;
            end
            OP_MTLO: begin
              lo_we = 1'b1;
              lo_d  = a;
            end
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (flush) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          stall_o = 1'b1;
          if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
            cnt_d = '0;
`ifdef MULDIV_ACC_EN
            if (acc_q) begin
              state_d = ST_ACC;
            end else begin
              hi_we   = 1'b1;
              lo_we   = 1'b1;
              hi_d    = prod[DLEN-1:XLEN];
              lo_d    = prod[XLEN-1:0];
              state_d = ST_DONE;
            end
`else
            hi_we   = 1'b1;
            lo_we   = 1'b1;
            hi_d    = prod[DLEN-1:XLEN];
            lo_d    = prod[XLEN-1:0];
            state_d = ST_DONE;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DIV: begin
        if (flush) begin
          div_annul = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          stall_o   = 1'b1;
          div_start = 1'b1;
          if (dv.div_ready_i) begin
            hi_we   = 1'b1;
            lo_we   = 1'b1;
            hi_d    = dv.div_result_i.rem;
            lo_d    = dv.div_result_i.quo;
            state_d = ST_DONE;
          end
        end
      end
`ifdef MULDIV_ACC_EN
      ST_ACC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          stall_o = 1'b1;
          hi_we   = 1'b1;
          lo_we   = 1'b1;
          hi_d    = acc_sum[DLEN-1:XLEN];
          lo_d    = acc_sum[XLEN-1:0];
          state_d = ST_DONE;
        end
      end
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_o <= '0;
      lo_o <= '0;
    end else begin
      if (hi_we) hi_o <= hi_d;
      if (lo_we) lo_o <= lo_d;
    end
  end

  // divider operands stay frozen for the whole DIV state
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_a_q   <= '0;
      div_b_q   <= '0;
      div_sgn_q <= 1'b0;
    end else if (div_load) begin
      div_a_q   <= a;
      div_b_q   <= b;
      div_sgn_q <= (e_op == OP_DIV);
    end
  end

  assign dv.div_start_o  = div_start;
  assign dv.div_annul_o  = div_annul & rst;
  assign dv.div_signed_o = div_sgn_q;
  assign dv.div_a_o      = div_a_q;
  assign dv.div_b_o      = div_b_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl (MUL_LAT=2) with a behavioural divider handshake model.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst;
  logic        e_valid;
  op_t         e_op;
  logic [31:0] a, b;
  logic        flush;
  logic        stall_o;
  logic [31:0] hi_o, lo_o;

  int          n_assert;
  int          n_fail;
  int          st, sp;

  logic [63:0] div_res_val;
  int          div_lat;
  logic        ready_q;
  int          dcnt;

  logic        seen_sgn;
  logic [31:0] seen_a, seen_b;
  logic        hold_ok;

  muldiv_ctrl_if dif();

  muldiv_ctrl #(.MUL_LAT(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .e_valid (e_valid),
    .e_op    (e_op),
    .a       (a),
    .b       (b),
    .flush   (flush),
    .stall_o (stall_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o),
    .dv      (dif)
  );

  assign dif.div_result_i = div_res_val;
  assign dif.div_ready_i  = ready_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // divider model: ready pulses in the div_lat-th cycle of div_start
  always @(posedge clk) begin
    if (!rst || dif.div_annul_o) begin
      ready_q <= 1'b0;
      dcnt    <= 0;
    end else if (ready_q) begin
      ready_q <= 1'b0;
      dcnt    <= 0;
    end else if (dif.div_start_o) begin
      dcnt <= dcnt + 1;
      if (dcnt + 1 == div_lat - 1) ready_q <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // issue one op held in E until the controller stops stalling, plus the following cycle
  task automatic run_op(input op_t op, input logic [31:0] av, input logic [31:0] bv,
                        output int stalls, output int starts);
    e_valid = 1'b1;
    e_op    = op;
    a       = av;
    b       = bv;
    stalls  = 0;
    starts  = 0;
    hold_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!stall_o) break;
      stalls++;
      if (dif.div_start_o) begin
        if (starts == 0) begin
          seen_sgn = dif.div_signed_o;
          seen_a   = dif.div_a_o;
          seen_b   = dif.div_b_o;
        end else if (dif.div_a_o !== seen_a || dif.div_b_o !== seen_b ||
                     dif.div_signed_o !== seen_sgn) begin
          hold_ok = 1'b0;
        end
        starts++;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    e_valid = 1'b0;
    e_op    = OP_NOP;
  endtask

  initial begin
    n_assert = 0; n_fail = 0;
    rst = 1'b0; e_valid = 1'b0; e_op = OP_NOP; a = '0; b = '0; flush = 1'b0;
    div_res_val = '0; div_lat = 34;
    seen_sgn = 1'b0; seen_a = '0; seen_b = '0; hold_ok = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_hi", 64'(hi_o), 64'h0);
    chk("rst_lo", 64'(lo_o), 64'h0);
    chk("rst_stall", 64'(stall_o), 64'h0);
    chk("rst_start", 64'(dif.div_start_o), 64'h0);
    chk("rst_annul", 64'(dif.div_annul_o), 64'h0);
    chk("rst_div_a", 64'(dif.div_a_o), 64'h0);
    chk("rst_div_b", 64'(dif.div_b_o), 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, st, sp);
    chk("mult_stall", 64'(st), 64'd3);
    chk("mult_hi", 64'(hi_o), 64'hFFFF_FFFF);
    chk("mult_lo", 64'(lo_o), 64'hFFFF_FFFA);

    run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, st, sp);
    chk("multu_stall", 64'(st), 64'd3);
    chk("multu_hi", 64'(hi_o), 64'h0000_0002);
    chk("multu_lo", 64'(lo_o), 64'hFFFF_FFFA);

    run_op(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st, sp);
    chk("mult_m1_hi", 64'(hi_o), 64'h0);
    chk("mult_m1_lo", 64'(lo_o), 64'h1);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st, sp);
    chk("multu_max_hi", 64'(hi_o), 64'hFFFF_FFFE);
    chk("multu_max_lo", 64'(lo_o), 64'h0000_0001);

    div_res_val = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, st, sp);
    chk("div_stall", 64'(st), 64'd35);
    chk("div_starts", 64'(sp), 64'd34);
    chk("div_signed", 64'(seen_sgn), 64'h1);
    chk("div_a", 64'(seen_a), 64'hFFFF_FFF9);
    chk("div_b", 64'(seen_b), 64'h2);
    chk("div_hold", 64'(hold_ok), 64'h1);
    chk("div_hi", 64'(hi_o), 64'hFFFF_FFFF);
    chk("div_lo", 64'(lo_o), 64'hFFFF_FFFD);

    run_op(OP_MTHI, 32'h1234_5678, 32'd0, st, sp);
    chk("mthi_stall", 64'(st), 64'd0);
    chk("mthi_hi", 64'(hi_o), 64'h1234_5678);
    chk("mthi_lo_keep", 64'(lo_o), 64'hFFFF_FFFD);
    run_op(OP_MTLO, 32'hCAFE_F00D, 32'd0, st, sp);
    chk("mtlo_lo", 64'(lo_o), 64'hCAFE_F00D);

    e_valid = 1'b1; e_op = OP_MTHI; a = 32'hDEAD_BEEF; flush = 1'b1;
    @(negedge clk);
    chk("mthi_flush_stall", 64'(stall_o), 64'h0);
    @(posedge clk); #1;
    e_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("mthi_flush_hi", 64'(hi_o), 64'h1234_5678);

    @(posedge clk); #1;
    div_res_val = {32'd2, 32'd14};
    e_valid = 1'b1; e_op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    chk("divu_accept_stall", 64'(stall_o), 64'h1);
    repeat (5) @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("divu_flush_annul", 64'(dif.div_annul_o), 64'h1);
    chk("divu_flush_stall", 64'(stall_o), 64'h0);
    chk("divu_signed", 64'(dif.div_signed_o), 64'h0);
    chk("divu_a", 64'(dif.div_a_o), 64'd100);
    @(posedge clk); #1;
    flush = 1'b0; e_valid = 1'b0;
    @(negedge clk);
    chk("divu_annul_once", 64'(dif.div_annul_o), 64'h0);
    chk("divu_post_stall", 64'(stall_o), 64'h0);
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("divu_flush_hi", 64'(hi_o), 64'h1234_5678);
    chk("divu_flush_lo", 64'(lo_o), 64'hCAFE_F00D);

    @(posedge clk); #1;
    e_valid = 1'b1; e_op = OP_MULT; a = 32'd5; b = 32'd7;
    @(posedge clk); #1;
    rst = 1'b0; e_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mulrst_hi", 64'(hi_o), 64'h0);
    chk("mulrst_lo", 64'(lo_o), 64'h0);
    chk("mulrst_stall", 64'(stall_o), 64'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("mulrst_late_lo", 64'(lo_o), 64'h0);
    @(posedge clk); #1;

    run_op(OP_MTLO, 32'h1, 32'd0, st, sp);
    chk("idle_mtlo_stall", 64'(st), 64'd0);
    chk("idle_mtlo_lo", 64'(lo_o), 64'h1);

    run_op(OP_NOP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, st, sp);
    chk("nop_stall", 64'(st), 64'd0);
    chk("nop_hilo", {32'(hi_o), 32'(lo_o)}, 64'h0000_0000_0000_0001);

    run_op(OP_MADD, 32'd2, 32'd3, st, sp);
`ifdef MULDIV_ACC_EN
    chk("madd_stall", 64'(st), 64'd4);
    chk("madd_hilo", {32'(hi_o), 32'(lo_o)}, 64'h0000_0000_0000_0007);
`else
    chk("madd_stall", 64'(st), 64'd0);
    chk("madd_hilo", {32'(hi_o), 32'(lo_o)}, 64'h0000_0000_0000_0001);
`endif

    run_op(OP_MSUBU, 32'd2, 32'd5, st, sp);
`ifdef MULDIV_ACC_EN
    chk("msubu_stall", 64'(st), 64'd4);
    chk("msubu_hilo", {32'(hi_o), 32'(lo_o)}, 64'hFFFF_FFFF_FFFF_FFFD);
`else
    chk("msubu_stall", 64'(st), 64'd0);
    chk("msubu_hilo", {32'(hi_o), 32'(lo_o)}, 64'h0000_0000_0000_0001);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
